// File: rtl/nap_pkg.sv
// Shared types and constants for the nap countdown timer.
package nap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t        MAX_TEN_MS   = 4'd5;
  localparam bcd_t        MAX_ONE      = 4'd9;
  localparam int unsigned MAX_HOURS    = 23;
  localparam bcd_t        MAX_HOUR_TEN = 4'd2;
  localparam int unsigned N_DIGITS     = 6;

  // Digit order: 0 sec_one, 1 sec_ten, 2 min_one, 3 min_ten, 4 hour_one, 5 hour_ten.
  function automatic bcd_t digit_max(int unsigned idx);
    case (idx)
      1, 3:    return MAX_TEN_MS;
      5:       return MAX_HOUR_TEN;
      default: return MAX_ONE;
    endcase
  endfunction

  function automatic logic hours_ok(bcd_t ten, bcd_t one);
    return ((32'(ten) * 32'd10) + 32'(one)) <= MAX_HOURS;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with load and borrow chaining.
module bcd_down_digit
  import nap_pkg::*;
#(
  parameter bcd_t MAX = MAX_ONE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic       borrow_in,
  output logic [3:0] value,
  output logic       borrow_out
);

  logic [3:0] r_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= 4'd0;
    end else if (load) begin
      r_value <= load_val;
    end else if (dec && borrow_in) begin
      r_value <= (r_value == 4'd0) ? MAX : r_value - 4'd1;
    end
  end

  assign value      = r_value;
  assign borrow_out = dec & borrow_in & (r_value == 4'd0);

endmodule

// File: rtl/nap_countdown.sv
// Nap countdown timer: load-edge detection, one-second prescaler, IDLE/RUN/ALARM FSM
// and a six-digit BCD borrow chain.
module nap_countdown
  import nap_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       completeSetting,
  input  logic [3:0] hour_ten_in,
  input  logic [3:0] hour_one_in,
  input  logic [3:0] min_ten_in,
  input  logic [3:0] min_one_in,
  input  logic [3:0] sec_ten_in,
  input  logic [3:0] sec_one_in,
  input  logic       stop,
  input  logic       pause,
  output logic [3:0] hour_ten_out,
  output logic [3:0] hour_one_out,
  output logic [3:0] min_ten_out,
  output logic [3:0] min_one_out,
  output logic [3:0] sec_ten_out,
  output logic [3:0] sec_one_out,
  output logic       running,
  output logic       alarm,
  output logic       err
);

  localparam int unsigned   PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_err, w_err_nxt;
  logic          r_running, r_alarm;
  logic          r_cs_q, r_armed;

  logic [3:0]          w_in  [N_DIGITS];
  logic [3:0]          w_val [N_DIGITS];
  logic [N_DIGITS:0]   w_borrow;
  logic                w_load_edge, w_valid, w_digits_ok, w_in_zero;
  logic                w_load, w_tick, w_dec, w_one_left;

  assign w_in[0] = sec_one_in;
  assign w_in[1] = sec_ten_in;
  assign w_in[2] = min_one_in;
  assign w_in[3] = min_ten_in;
  assign w_in[4] = hour_one_in;
  assign w_in[5] = hour_ten_in;

  // r_armed masks the first clock after reset so a level held high is not seen as an edge.
  assign w_load_edge = r_armed & completeSetting & ~r_cs_q;

  always_comb begin
    w_digits_ok = 1'b1;
    w_in_zero   = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (w_in[i] > MAX_ONE) w_digits_ok = 1'b0;
      if (w_in[i] != 4'd0)   w_in_zero   = 1'b0;
    end
  end

  assign w_valid = w_digits_ok & (sec_ten_in <= MAX_TEN_MS) & (min_ten_in <= MAX_TEN_MS)
                 & hours_ok(hour_ten_in, hour_one_in);

  assign w_load     = w_load_edge & w_valid;
  assign w_tick     = (r_state == RUN) & ~pause & (r_presc == PRESC_LAST);
  assign w_dec      = w_tick & ~w_load_edge & ~stop;
  assign w_one_left = ((w_val[5] | w_val[4] | w_val[3] | w_val[2] | w_val[1]) == 4'd0)
                    & (w_val[0] == 4'd1);

  assign w_borrow[0] = 1'b1;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    bcd_down_digit #(
      .MAX(digit_max(gi))
    ) u_digit (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .load_val  (w_in[gi]),
      .dec       (w_dec),
      .borrow_in (w_borrow[gi]),
      .value     (w_val[gi]),
      .borrow_out(w_borrow[gi+1])
    );
  end

  // Next-state: load edge beats stop, stop beats tick.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_err_nxt   = r_err;
    if (w_load_edge) begin
      w_presc_nxt = '0;
      if (w_valid) begin
        w_err_nxt   = 1'b0;
        w_state_nxt = w_in_zero ? ALARM : RUN;
      end else begin
        w_err_nxt   = 1'b1;
        w_state_nxt = IDLE;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (stop) begin
            w_state_nxt = IDLE;
            w_presc_nxt = '0;
          end else if (!pause) begin
            if (r_presc == PRESC_LAST) begin
              w_presc_nxt = '0;
              if (w_one_left || w_borrow[N_DIGITS]) w_state_nxt = ALARM;
            end else begin
              w_presc_nxt = r_presc + PW'(1);
            end
          end
        end
        ALARM: begin
          if (stop) w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_err     <= 1'b0;
      r_cs_q    <= 1'b0;
      r_armed   <= 1'b0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_err     <= w_err_nxt;
      r_cs_q    <= completeSetting;
      r_armed   <= 1'b1;
      r_running <= (w_state_nxt == RUN);
      r_alarm   <= (w_state_nxt == ALARM);
    end
  end

  assign sec_one_out  = w_val[0];
  assign sec_ten_out  = w_val[1];
  assign min_one_out  = w_val[2];
  assign min_ten_out  = w_val[3];
  assign hour_one_out = w_val[4];
  assign hour_ten_out = w_val[5];
  assign running      = r_running;
  assign alarm        = r_alarm;
  assign err          = r_err;

endmodule

// File: tb/tb_nap_countdown.sv
// Directed self-checking bench for nap_countdown with a 4-cycle tick.
module tb_nap_countdown;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [23:0] tin = 24'h000000;

  logic [3:0] hto, hoo, mto, moo, sto, soo;
  logic       running, alarm, err;
  logic [23:0] w_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nap_countdown #(.TICK_DIV(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .completeSetting(cs),
    .hour_ten_in    (tin[23:20]),
    .hour_one_in    (tin[19:16]),
    .min_ten_in     (tin[15:12]),
    .min_one_in     (tin[11:8]),
    .sec_ten_in     (tin[7:4]),
    .sec_one_in     (tin[3:0]),
    .stop           (stop),
    .pause          (pause),
    .hour_ten_out   (hto),
    .hour_one_out   (hoo),
    .min_ten_out    (mto),
    .min_one_out    (moo),
    .sec_ten_out    (sto),
    .sec_one_out    (soo),
    .running        (running),
    .alarm          (alarm),
    .err            (err)
  );

  assign w_out = {hto, hoo, mto, moo, sto, soo};

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [23:0] digits, input logic run,
                        input logic alm, input logic er);
    chk({tag, "_digits"}, w_out, digits);
    chk({tag, "_running"}, 24'(running), 24'(run));
    chk({tag, "_alarm"}, 24'(alarm), 24'(alm));
    chk({tag, "_err"}, 24'(err), 24'(er));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop completeSetting for one edge, then present the time and raise it; returns just after the load edge.
  task automatic load_time(input logic [23:0] t);
    cs = 1'b0;
    step(1);
    tin = t;
    cs  = 1'b1;
    step(1);
  endtask

  initial begin
    #12;
    chk_st("reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(2);

    // 00:00:03 runs out after three ticks
    load_time(24'h000003);
    chk_st("l3_load", 24'h000003, 1'b1, 1'b0, 1'b0);
    step(3);
    chk("l3_p3", w_out, 24'h000003);
    step(1);
    chk("l3_p4", w_out, 24'h000002);
    step(4);
    chk_st("l3_p8", 24'h000001, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_st("l3_p12", 24'h000000, 1'b0, 1'b1, 1'b0);
    step(3);
    chk_st("l3_hold", 24'h000000, 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    step(1);
    chk_st("l3_stop", 24'h000000, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_st("idle_stop", 24'h000000, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Full borrow chain from 01:00:00
    load_time(24'h010000);
    chk("h1_load", w_out, 24'h010000);
    step(4);
    chk("h1_tick", w_out, 24'h005959);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk_st("h1_stop", 24'h005959, 1'b0, 1'b0, 1'b0);
    step(4);
    chk("h1_idle", w_out, 24'h005959);

    // Pause for ten cycles starting at +2
    load_time(24'h000105);
    step(2);
    pause = 1'b1;
    step(10);
    chk_st("pz_held", 24'h000105, 1'b1, 1'b0, 1'b0);
    pause = 1'b0;
    step(1);
    chk("pz_p13", w_out, 24'h000105);
    step(1);
    chk("pz_p14", w_out, 24'h000104);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk_st("pz_stop", 24'h000104, 1'b0, 1'b0, 1'b0);

    // Rejected loads leave outputs alone
    load_time(24'h006100);
    chk_st("bad_min", 24'h000104, 1'b0, 1'b0, 1'b1);
    load_time(24'h240000);
    chk_st("bad_hour", 24'h000104, 1'b0, 1'b0, 1'b1);
    load_time(24'h00000A);
    chk_st("bad_digit", 24'h000104, 1'b0, 1'b0, 1'b1);
    load_time(24'h000005);
    chk_st("good_after_bad", 24'h000005, 1'b1, 1'b0, 1'b0);

    // Load edge, stop and tick in the same cycle: load wins
    cs = 1'b0;
    step(2);
    step(1);
    chk("sim_pre", w_out, 24'h000005);
    tin  = 24'h000007;
    cs   = 1'b1;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk_st("sim_load", 24'h000007, 1'b1, 1'b0, 1'b0);
    step(3);
    chk("sim_p3", w_out, 24'h000007);
    step(1);
    chk("sim_p4", w_out, 24'h000006);

    // Zero load goes straight to ALARM
    load_time(24'h000000);
    chk_st("zero_load", 24'h000000, 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk_st("zero_stop", 24'h000000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN, then a held completeSetting must not reload
    load_time(24'h000009);
    step(1);
    chk("rst_pre", w_out, 24'h000009);
    #3;
    rst = 1'b0;
    #1;
    chk_st("rst_async", 24'h000000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(3);
    chk_st("rst_held", 24'h000000, 1'b0, 1'b0, 1'b0);
    load_time(24'h000009);
    chk_st("rst_reload", 24'h000009, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
